fib_panel_ctrl: RTL
===================

Name: fib_panel_ctrl

Overview:
Parametrised front-panel request controller that sits between raw board push-buttons and a req/ack compute core such as fib.
- Debounces and edge-detects an active-low key bank.
- Holds an editable operand n and drives a four-phase req/ack handshake with timeout and abort.
- Captures each result into a holding register for the 7-segment display mux.
- Optional sweep mode re-launches automatically with n+1 until N_MAX.

Parameters:
N_IN, 7, operand width
N_OUT, 90, result width
N_DEFAULT, 60, n after reset
N_MAX, 90, upper saturation limit for n (must be < 2**N_IN)
DB_CYCLES, 65535, stable cycles required before a key change is accepted (>=1)
TIMEOUT, 1048575, max cycles in REQ waiting for ack
CNT_W, 16, width of done_cnt and lat_q

Ports:
clk  in  1  system clock
RSTN  in  1  asynchronous active-low reset
key_n  in  4  raw active-low keys: [0] start, [1] abort, [2] inc, [3] dec
sweep  in  1  level; 1 = auto-advance n after each completion
ack  in  1  handshake acknowledge from core
result  in  N_OUT  core result, valid while ack=1
req  out  1  handshake request to core
n  out  N_IN  operand to core
result_q  out  N_OUT  last captured result
busy  out  1  1 whenever state != IDLE
done_cnt  out  CNT_W  completed transactions, wraps
err_timeout  out  1  sticky timeout flag
lat_q  out  CNT_W  cycles from req rise to ack of last transaction

Behaviour:
- One clock; reset is asynchronous and active-low (clk, RSTN).
- Reset values: req=0, n=N_DEFAULT, result_q=0, busy=0, done_cnt=0, err_timeout=0, lat_q=0, state=IDLE, debounced keys=released (1).
- Key path, per bit:
  - 2-FF synchroniser, then debounce counter.
  - Counter clears whenever the synchronised value equals the debounced value.
  - Debounced value flips when counter reaches DB_CYCLES-1.
  - press pulse = debounced 1->0, exactly one cycle.
- Key to action latency: 2 + DB_CYCLES cycles to the press pulse, +1 to the state/reg update.
- FSM states:
  - IDLE: start press and no abort press -> REQ, req<=1. inc press -> n<=min(n+1,N_MAX). dec press -> n<=max(n-1,0). inc and dec in the same cycle -> n unchanged.
  - REQ: req=1, n frozen, timer increments each cycle.
    - ack=1 -> result_q<=result, done_cnt<=done_cnt+1, req<=0, -> DRAIN.
    - else abort press -> req<=0, stop_flag<=1, -> DRAIN.
    - else timer==TIMEOUT-1 -> err_timeout<=1, req<=0, stop_flag<=1, -> DRAIN.
    - ack has priority over abort/timeout in the same cycle.
  - DRAIN: req=0, wait for ack=0. An abort press here sets stop_flag.
    - On ack=0 with sweep=1, stop_flag=0, n<N_MAX -> n<=n+1, -> REQ (req re-asserts next cycle).
    - Otherwise -> IDLE, stop_flag<=0.
- start in REQ/DRAIN ignored; inc/dec outside IDLE ignored.
- err_timeout clears on the next accepted start.
- req never asserts while ack=1 (DRAIN guarantees ack low first).
- Reset mid-transaction: req drops asynchronously; core must tolerate req falling without ack.

Optional Feature:
Macro FIB_PANEL_LATENCY_EN.
- Defined: timer value at the ack cycle (cycles since req rose, first REQ cycle = 1), saturated at 2**CNT_W-1, loads lat_q on each completion; abort/timeout leave lat_q unchanged.
- Undefined: lat_q tied to 0, no latency logic synthesised.
- Port list identical either way.

Test Plan:
- DB_CYCLES=4, n=60, core acks 10 cycles after req: bench behaviour = req high 10 cycles; after ack, result_q=fib(60)=1548008755920, done_cnt=1, busy low one cycle after ack drops; lat_q=10 with macro, 0 without.
- Key bounce: key_n[2] toggles 3 times with 2-cycle spacing then holds low -> exactly one inc, n 60->61. inc+dec pressed the same cycle -> n unchanged. dec from n=0 -> stays 0. inc at N_MAX=90 -> stays 90.
- Core never acks, TIMEOUT=100: req falls after exactly 100 REQ cycles, err_timeout=1, state IDLE, done_cnt unchanged. Next start clears err_timeout.
- sweep=1, n=88, N_MAX=90: three transactions with n=88, 89, 90, then IDLE; done_cnt +3. An abort press during n=89 REQ -> no n=90 launch.
- start and abort pressed the same cycle in IDLE -> stays IDLE, req=0.
- RSTN low mid-REQ -> req=0 immediately, n=60, done_cnt=0; core acking later is ignored.

Source files
------------

// File: rtl/fib_panel_ctrl.sv
// Front-panel req/ack controller: key debounce, operand edit, handshake, result capture.
// Optional latency capture into lat_q is enabled by defining FIB_PANEL_LATENCY_EN.
module fib_panel_ctrl #(
   parameter int N_IN      = 7,
   parameter int N_OUT     = 90,
   parameter int N_DEFAULT = 60,
   parameter int N_MAX     = 90,
   parameter int DB_CYCLES = 65535,
   parameter int TIMEOUT   = 1048575,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             RSTN,
   input  logic [3:0]       key_n,
   input  logic             sweep,
   input  logic             ack,
   input  logic [N_OUT-1:0] result,
   output logic             req,
   output logic [N_IN-1:0]  n,
   output logic [N_OUT-1:0] result_q,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt,
   output logic             err_timeout,
   output logic [CNT_W-1:0] lat_q
);

   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state;
   logic [3:0]      sync1;
   logic [3:0]      sync2;
   logic [3:0]      db;
   logic [3:0]      press;
   logic [DB_W-1:0] db_cnt [4];
   logic [TW-1:0]   timer;
   logic            stop_flag;
   logic            start_p;
   logic            abort_p;
   logic            inc_p;
   logic            dec_p;

   assign start_p = press[0];
   assign abort_p = press[1];
   assign inc_p   = press[2];
   assign dec_p   = press[3];

   // press fires on the same edge the debounced level falls to 0
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         sync1 <= '1;
         sync2 <= '1;
         db    <= '1;
         press <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= '0;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
               press[i]  <= db[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state       <= IDLE;
         req         <= 1'b0;
         busy        <= 1'b0;
         n           <= N_IN'(N_DEFAULT);
         result_q    <= '0;
         done_cnt    <= '0;
         err_timeout <= 1'b0;
         stop_flag   <= 1'b0;
         timer       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_p && !abort_p) begin
                  state       <= REQ;
                  req         <= 1'b1;
                  busy        <= 1'b1;
                  timer       <= '0;
                  err_timeout <= 1'b0;
               end
               if (inc_p && !dec_p && n < N_IN'(N_MAX)) begin
                  n <= n + N_IN'(1);
               end else if (dec_p && !inc_p && n != '0) begin
                  n <= n - N_IN'(1);
               end
            end
            REQ: begin
               if (ack) begin
                  result_q <= result;
                  done_cnt <= done_cnt + CNT_W'(1);
                  req      <= 1'b0;
                  state    <= DRAIN;
               end else if (abort_p) begin
                  req       <= 1'b0;
                  stop_flag <= 1'b1;
                  state     <= DRAIN;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  req         <= 1'b0;
                  stop_flag   <= 1'b1;
                  state       <= DRAIN;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            DRAIN: begin
               if (!ack) begin
                  if (sweep && !stop_flag && !abort_p
                      && n < N_IN'(N_MAX)) begin
                     n     <= n + N_IN'(1);
                     state <= REQ;
                     req   <= 1'b1;
                     timer <= '0;
                  end else begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     stop_flag <= 1'b0;
                  end
               end else if (abort_p) begin
                  stop_flag <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               req   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIB_PANEL_LATENCY_EN
   localparam logic [63:0] LAT_MAX = (64'd1 << CNT_W) - 64'd1;

   logic [63:0]      lat_t;
   logic [CNT_W-1:0] lat_v;
   logic [CNT_W-1:0] lat_r;

   // timer counts from 0 in the first REQ cycle, so latency is timer+1
   always_comb begin
      lat_t = 64'(timer) + 64'd1;
      lat_v = (lat_t > LAT_MAX) ? '1 : lat_t[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         lat_r <= '0;
      end else if (state == REQ && ack) begin
         lat_r <= lat_v;
      end
   end

   assign lat_q = lat_r;
`else
   assign lat_q = '0;
`endif

endmodule
